// File: rtl/tft_pix_gen.sv
// TFT test-pattern generator: colour bars, grid and a bouncing box, with
// a 1-cycle registered RGB565 pixel and a frame-synchronous pattern switch.
module tft_pix_gen #(
    parameter int unsigned H_VALID  = 480,
    parameter int unsigned V_VALID  = 272,
    parameter int unsigned BOX_SIZE = 32,
    parameter int unsigned BOX_STEP = 2
) (
    input  logic        clk_9m,
    input  logic        sys_rst,
    input  logic [9:0]  pix_x,
    input  logic [9:0]  pix_y,
    input  logic        mode_key,
    output logic [15:0] pix_data,
    output logic [1:0]  mode
);

    localparam logic [9:0]  PIX_NONE  = 10'h3FF;
    localparam logic [9:0]  X_LAST    = 10'(H_VALID - 1);
    localparam logic [9:0]  Y_LAST    = 10'(V_VALID - 1);
    localparam logic [9:0]  BOX_MAX_X = 10'(H_VALID - BOX_SIZE);
    localparam logic [9:0]  BOX_MAX_Y = 10'(V_VALID - BOX_SIZE);
    localparam logic [9:0]  STEP      = 10'(BOX_STEP);
    localparam logic [10:0] BOX_SZ11  = 11'(BOX_SIZE);
    localparam logic [9:0]  BAR_W     = 10'(H_VALID / 8);

    typedef enum logic [1:0] {
        MODE_BAR  = 2'd0,
        MODE_GRID = 2'd1,
        MODE_BOX  = 2'd2
    } mode_e;

    mode_e       mode_q;
    logic        pending;
    logic [9:0]  pix_y_q;
    logic [9:0]  box_x;
    logic [9:0]  box_y;
    logic        dir_x;
    logic        dir_y;
    logic        frame_end_c;
    logic        in_box_c;
    logic [9:0]  bar_idx_c;
    logic [15:0] pix_next_c;

    // Frame ends on the first blanking cycle after the last active row.
    assign frame_end_c = (pix_y_q == Y_LAST) && (pix_y == PIX_NONE);

    assign mode = mode_q;

    // Box hit test in 11 bits so the far edge never wraps.
    assign in_box_c = ({1'b0, pix_x} >= {1'b0, box_x}) &&
                      ({1'b0, pix_x} <  ({1'b0, box_x} + BOX_SZ11)) &&
                      ({1'b0, pix_y} >= {1'b0, box_y}) &&
                      ({1'b0, pix_y} <  ({1'b0, box_y} + BOX_SZ11));

    // Pattern colour for the requested coordinate.
    always_comb begin
        pix_next_c = 16'h0000;
        bar_idx_c  = pix_x / BAR_W;
        if ((pix_x != PIX_NONE) && (pix_y != PIX_NONE)) begin
            case (mode_q)
                MODE_BAR: begin
                    case (bar_idx_c)
                        10'd0:   pix_next_c = 16'hFFFF;
                        10'd1:   pix_next_c = 16'hFFE0;
                        10'd2:   pix_next_c = 16'h07FF;
                        10'd3:   pix_next_c = 16'h07E0;
                        10'd4:   pix_next_c = 16'hF81F;
                        10'd5:   pix_next_c = 16'hF800;
                        10'd6:   pix_next_c = 16'h001F;
                        default: pix_next_c = 16'h0000;
                    endcase
                end
                MODE_GRID: begin
                    if ((pix_x[4:0] == 5'd0) || (pix_y[4:0] == 5'd0) ||
                        (pix_x == X_LAST) || (pix_y == Y_LAST))
                        pix_next_c = 16'hFFFF;
                end
                MODE_BOX: begin
                    pix_next_c = in_box_c ? 16'hF800 : 16'h001F;
                end
                default: pix_next_c = 16'h0000;
            endcase
        end
    end

    // Registered pixel output.
    always_ff @(posedge clk_9m) begin
        if (sys_rst) pix_data <= 16'h0000;
        else         pix_data <= pix_next_c;
    end

    // Delayed row for frame-end detection; reset value cannot match the last row.
    always_ff @(posedge clk_9m) begin
        if (sys_rst) pix_y_q <= PIX_NONE;
        else         pix_y_q <= pix_y;
    end

    // Horizontal box motion, bouncing at both edges once per frame.
    always_ff @(posedge clk_9m) begin
        if (sys_rst) begin
            box_x <= 10'd0;
            dir_x <= 1'b1;
        end else if (frame_end_c) begin
            if (dir_x) begin
                if (box_x == BOX_MAX_X) begin
                    dir_x <= 1'b0;
                    box_x <= BOX_MAX_X - STEP;
                end else begin
                    box_x <= box_x + STEP;
                end
            end else begin
                if (box_x == 10'd0) begin
                    dir_x <= 1'b1;
                    box_x <= STEP;
                end else begin
                    box_x <= box_x - STEP;
                end
            end
        end
    end

    // Vertical box motion, bouncing at both edges once per frame.
    always_ff @(posedge clk_9m) begin
        if (sys_rst) begin
            box_y <= 10'd0;
            dir_y <= 1'b1;
        end else if (frame_end_c) begin
            if (dir_y) begin
                if (box_y == BOX_MAX_Y) begin
                    dir_y <= 1'b0;
                    box_y <= BOX_MAX_Y - STEP;
                end else begin
                    box_y <= box_y + STEP;
                end
            end else begin
                if (box_y == 10'd0) begin
                    dir_y <= 1'b1;
                    box_y <= STEP;
                end else begin
                    box_y <= box_y - STEP;
                end
            end
        end
    end

    // Pattern FSM: a key press is latched and applied at the next frame end.
    always_ff @(posedge clk_9m) begin
        if (sys_rst) begin
            mode_q  <= MODE_BAR;
            pending <= 1'b0;
        end else if (frame_end_c) begin
            if (pending || mode_key) begin
                case (mode_q)
                    MODE_BAR:  mode_q <= MODE_GRID;
                    MODE_GRID: mode_q <= MODE_BOX;
                    default:   mode_q <= MODE_BAR;
                endcase
            end
            pending <= 1'b0;
        end else if (mode_key) begin
            pending <= 1'b1;
        end
    end

endmodule
